// File: rtl/kf8237_pkg.sv
// Shared types for the KF8237 address and word-count register file.
package kf8237_pkg;

  localparam int CHANNELS = 4;

  typedef logic [1:0]  chan_idx_t;
  typedef logic [15:0] word_t;

  // Which half of a 16-bit register the CPU byte pointer addresses.
  typedef enum logic {
    BYTE_LOW  = 1'b0,
    BYTE_HIGH = 1'b1
  } byte_sel_e;

  // Replace one byte of a 16-bit register, leaving the other byte intact.
  function automatic word_t write_byte(input word_t old_value, input byte_sel_e sel,
                                       input logic [7:0] data);
    word_t result;
    result = old_value;
    if (sel == BYTE_LOW) result[7:0] = data;
    else                 result[15:8] = data;
    return result;
  endfunction

  // Pick the byte of a 16-bit register that the byte pointer addresses.
  function automatic logic [7:0] pick_byte(input word_t value, input byte_sel_e sel);
    return (sel == BYTE_LOW) ? value[7:0] : value[15:8];
  endfunction

endpackage

// File: rtl/kf8237_channel_counter.sv
// One DMA channel: base/current address and word count, stepping,
// autoinitialize reload and CPU byte writes. Write/step arbitration is
// done by the parent, so step and reload_request arrive already gated.
module kf8237_channel_counter
  import kf8237_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        write_address,
  input  logic        write_count,
  input  byte_sel_e   byte_sel,
  input  logic        step,
  input  logic        reload_request,
  input  logic        decrement,
  input  logic        autoinit,
  output word_t       current_address,
  output word_t       current_count,
  output logic        terminal_count
);

  word_t base_address_q, base_address_d;
  word_t current_address_q, current_address_d;
  word_t base_count_q, base_count_d;
  word_t current_count_q, current_count_d;
  logic  tc_q, tc_d;
  logic  count_zero;

  assign count_zero = (current_count_q == 16'h0000);

  // Next-state: step, then reload overrides the step, then CPU writes land.
  always_comb begin
    base_address_d    = base_address_q;
    current_address_d = current_address_q;
    base_count_d      = base_count_q;
    current_count_d   = current_count_q;
    tc_d              = step && count_zero;

    if (step) begin
      current_address_d = decrement ? (current_address_q - 16'd1)
                                    : (current_address_q + 16'd1);
      current_count_d   = current_count_q - 16'd1;
    end

    if (autoinit && (reload_request || (step && count_zero))) begin
      current_address_d = base_address_q;
      current_count_d   = base_count_q;
    end

    if (write_address) begin
      base_address_d    = write_byte(base_address_q, byte_sel, data_in);
      current_address_d = write_byte(current_address_q, byte_sel, data_in);
    end

    if (write_count) begin
      base_count_d    = write_byte(base_count_q, byte_sel, data_in);
      current_count_d = write_byte(current_count_q, byte_sel, data_in);
    end
  end

  // Register state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_address_q    <= '0;
      current_address_q <= '0;
      base_count_q      <= '0;
      current_count_q   <= '0;
      tc_q              <= 1'b0;
    end else begin
      base_address_q    <= base_address_d;
      current_address_q <= current_address_d;
      base_count_q      <= base_count_d;
      current_count_q   <= current_count_d;
      tc_q              <= tc_d;
    end
  end

  assign current_address = current_address_q;
  assign current_count   = current_count_q;
  assign terminal_count  = tc_q;

endmodule

// File: rtl/kf8237_address_and_count.sv
// KF8237 address/word-count register file: four channel counters plus the
// shared byte pointer, CPU read mux and write-versus-step arbitration.
module kf8237_address_and_count
  import kf8237_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  internal_data_bus,
  input  logic [3:0]  write_base_and_current_address,
  input  logic [3:0]  write_base_and_current_word_count,
  input  logic        clear_byte_pointer,
  input  logic        master_clear,
  input  logic [3:0]  read_current_address,
  input  logic [3:0]  read_current_word_count,
  output logic [7:0]  data_bus_out,
  input  logic [1:0]  transfer_channel,
  input  logic        transfer_step,
  input  logic [3:0]  address_decrement,
  input  logic [3:0]  autoinitialize,
  input  logic        eop_reload,
  output logic [15:0] transfer_address,
  output logic        word_count_zero,
  output logic [3:0]  terminal_count
);

  byte_sel_e byte_pointer_q, byte_pointer_d;
  logic      read_active_q, read_active_d;
  logic      any_write;
  logic [CHANNELS-1:0] step_en;
  logic [CHANNELS-1:0] reload_en;
  word_t     current_address [CHANNELS];
  word_t     current_count   [CHANNELS];

  assign any_write = (|write_base_and_current_address) | (|write_base_and_current_word_count);

  // Route step/EOP to the serviced channel; a CPU write to that channel drops both.
  always_comb begin
    step_en   = '0;
    reload_en = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((transfer_channel == chan_idx_t'(i)) &&
          !(write_base_and_current_address[i] || write_base_and_current_word_count[i])) begin
        step_en[i]   = transfer_step;
        reload_en[i] = eop_reload;
      end
    end
  end

  // Byte pointer toggles per write cycle or at the end of a read; clears win.
  always_comb begin
    read_active_d  = (|read_current_address) | (|read_current_word_count);
    byte_pointer_d = byte_pointer_q;
    if (any_write || (read_active_q && !read_active_d)) begin
      byte_pointer_d = (byte_pointer_q == BYTE_LOW) ? BYTE_HIGH : BYTE_LOW;
    end
    if (clear_byte_pointer || master_clear) begin
      byte_pointer_d = BYTE_LOW;
    end
  end

  // Byte pointer and read-strobe history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_pointer_q <= BYTE_LOW;
      read_active_q  <= 1'b0;
    end else begin
      byte_pointer_q <= byte_pointer_d;
      read_active_q  <= read_active_d;
    end
  end

  // Read mux: any address select beats any count select; lowest channel wins.
  always_comb begin
    data_bus_out = 8'h00;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (read_current_word_count[i]) data_bus_out = pick_byte(current_count[i], byte_pointer_q);
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (read_current_address[i]) data_bus_out = pick_byte(current_address[i], byte_pointer_q);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_channel
    kf8237_channel_counter u_counter (
      .clock           (clock),
      .reset           (reset),
      .data_in         (internal_data_bus),
      .write_address   (write_base_and_current_address[g]),
      .write_count     (write_base_and_current_word_count[g]),
      .byte_sel        (byte_pointer_q),
      .step            (step_en[g]),
      .reload_request  (reload_en[g]),
      .decrement       (address_decrement[g]),
      .autoinit        (autoinitialize[g]),
      .current_address (current_address[g]),
      .current_count   (current_count[g]),
      .terminal_count  (terminal_count[g])
    );
  end

  assign transfer_address = current_address[transfer_channel];
  assign word_count_zero  = (current_count[transfer_channel] == 16'h0000);

endmodule

// File: tb/tb_kf8237_address_and_count.sv
// Self-checking bench for kf8237_address_and_count: directed scenarios then
// random traffic, all compared against a behavioural register-file model.
module tb_kf8237_address_and_count;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  internal_data_bus;
  logic [3:0]  write_base_and_current_address;
  logic [3:0]  write_base_and_current_word_count;
  logic        clear_byte_pointer;
  logic        master_clear;
  logic [3:0]  read_current_address;
  logic [3:0]  read_current_word_count;
  logic [7:0]  data_bus_out;
  logic [1:0]  transfer_channel;
  logic        transfer_step;
  logic [3:0]  address_decrement;
  logic [3:0]  autoinitialize;
  logic        eop_reload;
  logic [15:0] transfer_address;
  logic        word_count_zero;
  logic [3:0]  terminal_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_ba [4];
  logic [15:0] m_ca [4];
  logic [15:0] m_bc [4];
  logic [15:0] m_cc [4];
  logic [3:0]  m_tc;
  logic        m_ptr;
  logic        m_rd_prev;

  kf8237_address_and_count dut (
    .clock                             (clock),
    .reset                             (reset),
    .internal_data_bus                 (internal_data_bus),
    .write_base_and_current_address    (write_base_and_current_address),
    .write_base_and_current_word_count (write_base_and_current_word_count),
    .clear_byte_pointer                (clear_byte_pointer),
    .master_clear                      (master_clear),
    .read_current_address              (read_current_address),
    .read_current_word_count           (read_current_word_count),
    .data_bus_out                      (data_bus_out),
    .transfer_channel                  (transfer_channel),
    .transfer_step                     (transfer_step),
    .address_decrement                 (address_decrement),
    .autoinitialize                    (autoinitialize),
    .eop_reload                        (eop_reload),
    .transfer_address                  (transfer_address),
    .word_count_zero                   (word_count_zero),
    .terminal_count                    (terminal_count)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Expected read data: first address select found from channel 0 up,
  // otherwise first count select, byte chosen by the model pointer.
  function automatic logic [7:0] modelRead();
    int sel = -1;
    bit is_addr = 1'b0;
    logic [15:0] w;
    for (int i = 0; i < 4; i++)
      if (read_current_address[i] && sel < 0) begin sel = i; is_addr = 1'b1; end
    if (sel < 0)
      for (int i = 0; i < 4; i++)
        if (read_current_word_count[i] && sel < 0) sel = i;
    if (sel < 0) return 8'h00;
    w = is_addr ? m_ca[sel] : m_cc[sel];
    return m_ptr ? 8'(w >> 8) : 8'(w & 16'h00FF);
  endfunction

  // One clock cycle: check combinational outputs, advance model and DUT,
  // check the registered TC, then drop the one-cycle pulses.
  task automatic applyStimulus();
    logic [15:0] nba [4];
    logic [15:0] nca [4];
    logic [15:0] nbc [4];
    logic [15:0] ncc [4];
    logic [3:0]  ntc;
    logic        nptr;
    logic        rd_now;
    int          c;
    #1;
    checkOutput("data_bus_out", {8'h00, data_bus_out}, {8'h00, modelRead()});
    checkOutput("transfer_address", transfer_address, m_ca[transfer_channel]);
    checkOutput("word_count_zero", {15'd0, word_count_zero},
                {15'd0, (m_cc[transfer_channel] == 16'd0)});
    for (int i = 0; i < 4; i++) begin
      nba[i] = m_ba[i]; nca[i] = m_ca[i]; nbc[i] = m_bc[i]; ncc[i] = m_cc[i];
    end
    ntc = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (write_base_and_current_address[i]) begin
        if (m_ptr) begin nba[i][15:8] = internal_data_bus; nca[i][15:8] = internal_data_bus; end
        else       begin nba[i][7:0]  = internal_data_bus; nca[i][7:0]  = internal_data_bus; end
      end
      if (write_base_and_current_word_count[i]) begin
        if (m_ptr) begin nbc[i][15:8] = internal_data_bus; ncc[i][15:8] = internal_data_bus; end
        else       begin nbc[i][7:0]  = internal_data_bus; ncc[i][7:0]  = internal_data_bus; end
      end
    end
    c = int'(transfer_channel);
    if (!(write_base_and_current_address[c] || write_base_and_current_word_count[c])) begin
      if (transfer_step) begin
        if (m_cc[c] == 16'd0) ntc[c] = 1'b1;
        if (m_cc[c] == 16'd0 && autoinitialize[c]) begin
          nca[c] = m_ba[c]; ncc[c] = m_bc[c];
        end else begin
          nca[c] = 16'((address_decrement[c] ? (int'(m_ca[c]) + 65535) : (int'(m_ca[c]) + 1)) % 65536);
          ncc[c] = 16'((int'(m_cc[c]) + 65535) % 65536);
        end
      end
      if (eop_reload && autoinitialize[c]) begin
        nca[c] = m_ba[c]; ncc[c] = m_bc[c];
      end
    end
    rd_now = (read_current_address != 4'd0) || (read_current_word_count != 4'd0);
    nptr = m_ptr;
    if (write_base_and_current_address != 4'd0 || write_base_and_current_word_count != 4'd0 ||
        (m_rd_prev && !rd_now)) nptr = !m_ptr;
    if (clear_byte_pointer || master_clear) nptr = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_ba[i] = nba[i]; m_ca[i] = nca[i]; m_bc[i] = nbc[i]; m_cc[i] = ncc[i];
    end
    m_tc = ntc;
    m_ptr = nptr;
    m_rd_prev = rd_now;
    checkOutput("terminal_count", {12'd0, terminal_count}, {12'd0, m_tc});
    write_base_and_current_address    = 4'd0;
    write_base_and_current_word_count = 4'd0;
    clear_byte_pointer = 1'b0;
    master_clear       = 1'b0;
    transfer_step      = 1'b0;
    eop_reload         = 1'b0;
  endtask

  task automatic writeReg(input bit is_count, input int ch, input logic [7:0] data);
    internal_data_bus = data;
    if (is_count) write_base_and_current_word_count[ch] = 1'b1;
    else          write_base_and_current_address[ch] = 1'b1;
    applyStimulus();
  endtask

  // Two-byte read through the data bus; pointer must be at the low byte.
  task automatic readWord(input bit is_count, input int ch, output logic [15:0] w);
    for (int b = 0; b < 2; b++) begin
      if (is_count) read_current_word_count[ch] = 1'b1;
      else          read_current_address[ch] = 1'b1;
      #1;
      if (b == 0) w[7:0] = data_bus_out; else w[15:8] = data_bus_out;
      applyStimulus();
      read_current_address    = 4'd0;
      read_current_word_count = 4'd0;
      applyStimulus();
    end
  endtask

  task automatic doStep(input int ch);
    transfer_channel = 2'(ch);
    transfer_step = 1'b1;
    applyStimulus();
  endtask

  initial begin
    logic [15:0] w;
    reset = 1'b1;
    internal_data_bus = 8'h00;
    write_base_and_current_address = 4'd0;
    write_base_and_current_word_count = 4'd0;
    clear_byte_pointer = 1'b0;
    master_clear = 1'b0;
    read_current_address = 4'd0;
    read_current_word_count = 4'd0;
    transfer_channel = 2'd0;
    transfer_step = 1'b0;
    address_decrement = 4'd0;
    autoinitialize = 4'd0;
    eop_reload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_ba[i] = 16'd0; m_ca[i] = 16'd0; m_bc[i] = 16'd0; m_cc[i] = 16'd0;
    end
    m_tc = 4'd0; m_ptr = 1'b0; m_rd_prev = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("reset_tc", {12'd0, terminal_count}, 16'h0000);
    checkOutput("reset_data_bus", {8'h00, data_bus_out}, 16'h0000);
    checkOutput("reset_address", transfer_address, 16'h0000);
    checkOutput("reset_count_zero", {15'd0, word_count_zero}, 16'h0001);

    // CPU write and read-back on channel 2
    writeReg(0, 2, 8'h34);
    writeReg(0, 2, 8'h12);
    readWord(0, 2, w);
    checkOutput("ch2_address_read", w, 16'h1234);
    readWord(0, 2, w);
    checkOutput("ch2_address_reread", w, 16'h1234);

    // Increment stepping to terminal count on channel 0
    writeReg(0, 0, 8'h00); writeReg(0, 0, 8'h10);
    writeReg(1, 0, 8'h01); writeReg(1, 0, 8'h00);
    doStep(0);
    checkOutput("step1_tc", {12'd0, terminal_count}, 16'h0000);
    doStep(0);
    checkOutput("step2_tc", {12'd0, terminal_count}, 16'h0001);
    checkOutput("step2_address", transfer_address, 16'h1002);
    applyStimulus();
    checkOutput("tc_single_pulse", {12'd0, terminal_count}, 16'h0000);
    readWord(1, 0, w);
    checkOutput("step2_count", w, 16'hFFFF);

    // Same with autoinitialize
    writeReg(0, 0, 8'h00); writeReg(0, 0, 8'h10);
    writeReg(1, 0, 8'h01); writeReg(1, 0, 8'h00);
    autoinitialize = 4'b0001;
    doStep(0);
    doStep(0);
    checkOutput("autoinit_tc", {12'd0, terminal_count}, 16'h0001);
    checkOutput("autoinit_address", transfer_address, 16'h1000);
    readWord(1, 0, w);
    checkOutput("autoinit_count", w, 16'h0001);

    // Address wrap in both directions on channel 1
    writeReg(0, 1, 8'h00); writeReg(0, 1, 8'h00);
    address_decrement = 4'b0010;
    doStep(1);
    checkOutput("decrement_wrap", transfer_address, 16'hFFFF);
    address_decrement = 4'b0000;
    doStep(1);
    checkOutput("increment_wrap", transfer_address, 16'h0000);

    // Clear byte pointer after a low-byte write
    writeReg(0, 3, 8'h55);
    clear_byte_pointer = 1'b1;
    applyStimulus();
    writeReg(0, 3, 8'hAB);
    transfer_channel = 2'd3;
    #1;
    checkOutput("clear_pointer_low", transfer_address, 16'h00AB);
    // CPU write colliding with a step on channel 3 (count 0): step dropped
    internal_data_bus = 8'h00;
    write_base_and_current_word_count[3] = 1'b1;
    transfer_step = 1'b1;
    applyStimulus();
    checkOutput("conflict_no_tc", {12'd0, terminal_count}, 16'h0000);
    checkOutput("conflict_address", transfer_address, 16'h00AB);

    // EOP reload on channel 2
    autoinitialize = 4'b0000;
    doStep(2);
    checkOutput("ch2_step", transfer_address, 16'h1235);
    eop_reload = 1'b1;
    applyStimulus();
    checkOutput("eop_no_autoinit", transfer_address, 16'h1235);
    autoinitialize = 4'b0100;
    eop_reload = 1'b1;
    applyStimulus();
    checkOutput("eop_autoinit_address", transfer_address, 16'h1234);
    checkOutput("eop_no_tc", {12'd0, terminal_count}, 16'h0000);
    checkOutput("eop_count_zero", {15'd0, word_count_zero}, 16'h0001);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      internal_data_bus = 8'($urandom);
      if ($urandom_range(0, 5) == 0) write_base_and_current_address = 4'($urandom);
      if ($urandom_range(0, 5) == 0) write_base_and_current_word_count = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        read_current_address    = 4'($urandom) & 4'($urandom);
        read_current_word_count = 4'($urandom) & 4'($urandom);
      end else begin
        read_current_address    = 4'd0;
        read_current_word_count = 4'd0;
      end
      clear_byte_pointer = ($urandom_range(0, 15) == 0);
      master_clear       = ($urandom_range(0, 31) == 0);
      transfer_channel   = 2'($urandom);
      transfer_step      = ($urandom_range(0, 1) == 0);
      eop_reload         = ($urandom_range(0, 9) == 0);
      address_decrement  = 4'($urandom);
      autoinitialize     = 4'($urandom);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
